// File: rtl/rat_ckpt.sv
// rtl/rat_ckpt.sv - register alias table with same-group bypass and branch checkpoints
module rat_ckpt #(
  parameter int NUM_AREGS    = 32,
  parameter int NUM_PREGS    = 64,
  parameter int RENAME_WIDTH = 2,
  parameter int NUM_CKPTS    = 4,
  localparam int AW = $clog2(NUM_AREGS),
  localparam int PW = $clog2(NUM_PREGS),
  localparam int CW = $clog2(NUM_CKPTS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [2*AW*RENAME_WIDTH-1:0]   src_areg_i,
  output logic [2*PW*RENAME_WIDTH-1:0]   src_preg_o,
  input  logic [RENAME_WIDTH-1:0]        w_en_i,
  input  logic [AW*RENAME_WIDTH-1:0]     dst_areg_i,
  input  logic [PW*RENAME_WIDTH-1:0]     new_preg_i,
  output logic [PW*RENAME_WIDTH-1:0]     old_preg_o,
  input  logic                           ckpt_take_i,
  output logic                           ckpt_ready_o,
  output logic [CW-1:0]                  ckpt_id_o,
  input  logic                           ckpt_release_i,
  input  logic [CW-1:0]                  ckpt_release_id_i,
  input  logic                           restore_i,
  input  logic [CW-1:0]                  restore_id_i,
  input  logic [NUM_CKPTS-1:0]           restore_kill_mask_i
);

  logic [PW-1:0]        table_q [NUM_AREGS];
  logic [PW-1:0]        wr_tab  [NUM_AREGS];
  logic [PW-1:0]        snap_q  [NUM_CKPTS][NUM_AREGS];
  logic [NUM_CKPTS-1:0] busy_q;
  logic [NUM_CKPTS-1:0] busy_d;
  logic                 take_fire;

  // Oldest-to-youngest scan so the youngest older lane writing areg a wins.
  function automatic logic [PW-1:0] lookup(input logic [AW-1:0] a, input int k);
    logic [PW-1:0] v;
    v = table_q[a];
    for (int j = 0; j < RENAME_WIDTH; j++) begin
      if (j < k && w_en_i[j] && dst_areg_i[AW*j +: AW] == a)
        v = new_preg_i[PW*j +: PW];
    end
    return v;
  endfunction

  always_comb begin
    src_preg_o = '0;
    old_preg_o = '0;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      for (int s = 0; s < 2; s++)
        src_preg_o[2*PW*k + PW*s +: PW] = lookup(src_areg_i[2*AW*k + AW*s +: AW], k);
      old_preg_o[PW*k +: PW] = lookup(dst_areg_i[AW*k +: AW], k);
    end
  end

  always_comb begin
    wr_tab = table_q;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      if (w_en_i[k])
        wr_tab[dst_areg_i[AW*k +: AW]] = new_preg_i[PW*k +: PW];
    end
  end

  always_comb begin
    ckpt_ready_o = ~&busy_q;
    ckpt_id_o    = '0;
    for (int i = NUM_CKPTS - 1; i >= 0; i--) begin
      if (!busy_q[i])
        ckpt_id_o = CW'(i);
    end
  end

  assign take_fire = ckpt_take_i && ckpt_ready_o && !restore_i;

  // The granted slot is free at cycle start, so it never collides with a release.
  always_comb begin
    busy_d = busy_q;
    if (ckpt_release_i)
      busy_d[ckpt_release_id_i] = 1'b0;
    if (take_fire)
      busy_d[ckpt_id_o] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_AREGS; i++)
        table_q[i] <= PW'(i);
      busy_q <= '0;
    end else if (restore_i) begin
      table_q <= snap_q[restore_id_i];
      busy_q  <= busy_q & ~restore_kill_mask_i & ~(NUM_CKPTS'(1) << restore_id_i);
    end else begin
      table_q <= wr_tab;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && take_fire)
      snap_q[ckpt_id_o] <= wr_tab;
  end

endmodule

// File: tb/tb_rat_ckpt.sv
// tb/tb_rat_ckpt.sv - scoreboard bench for rat_ckpt against a sequential rename model
module tb_rat_ckpt;
  localparam int NA = 32;
  localparam int NP = 64;
  localparam int RW = 2;
  localparam int NC = 4;
  localparam int AW = 5;
  localparam int PW = 6;
  localparam int CW = 2;

  logic                 clk;
  logic                 rst;
  logic [2*AW*RW-1:0]   src_areg_i;
  logic [2*PW*RW-1:0]   src_preg_o;
  logic [RW-1:0]        w_en_i;
  logic [AW*RW-1:0]     dst_areg_i;
  logic [PW*RW-1:0]     new_preg_i;
  logic [PW*RW-1:0]     old_preg_o;
  logic                 ckpt_take_i;
  logic                 ckpt_ready_o;
  logic [CW-1:0]        ckpt_id_o;
  logic                 ckpt_release_i;
  logic [CW-1:0]        ckpt_release_id_i;
  logic                 restore_i;
  logic [CW-1:0]        restore_id_i;
  logic [NC-1:0]        restore_kill_mask_i;

  rat_ckpt #(.NUM_AREGS(NA), .NUM_PREGS(NP), .RENAME_WIDTH(RW), .NUM_CKPTS(NC)) dut (
    .clk(clk), .rst(rst),
    .src_areg_i(src_areg_i), .src_preg_o(src_preg_o),
    .w_en_i(w_en_i), .dst_areg_i(dst_areg_i), .new_preg_i(new_preg_i), .old_preg_o(old_preg_o),
    .ckpt_take_i(ckpt_take_i), .ckpt_ready_o(ckpt_ready_o), .ckpt_id_o(ckpt_id_o),
    .ckpt_release_i(ckpt_release_i), .ckpt_release_id_i(ckpt_release_id_i),
    .restore_i(restore_i), .restore_id_i(restore_id_i), .restore_kill_mask_i(restore_kill_mask_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2*PW*RW-1:0] src;
    logic [PW*RW-1:0]   old;
    logic [RW-1:0]      oldv;
    logic               rdy;
    logic [CW-1:0]      id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: the table as an int array, snapshots as copies, busy flags per slot.
  int   m_tab [NA];
  int   m_snap[NC][NA];
  bit   m_busy[NC];

  // Stimulus staging, set by the sequences and applied by step().
  logic               s_rst, s_take, s_rel, s_res;
  logic [2*AW*RW-1:0] s_src;
  logic [RW-1:0]      s_wen;
  logic [AW*RW-1:0]   s_dst;
  logic [PW*RW-1:0]   s_new;
  logic [CW-1:0]      s_relid, s_resid;
  logic [NC-1:0]      s_kmask;

  task automatic idle();
    s_rst = 0; s_take = 0; s_rel = 0; s_res = 0;
    s_src = '0; s_wen = '0; s_dst = '0; s_new = '0;
    s_relid = '0; s_resid = '0; s_kmask = '0;
  endtask

  task automatic set_src(input int lane, input int s, input int a);
    s_src[2*AW*lane + AW*s +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int lane, input int a, input int p);
    s_wen[lane] = 1'b1;
    s_dst[AW*lane +: AW] = AW'(a);
    s_new[PW*lane +: PW] = PW'(p);
  endtask

  task automatic step();
    exp_t e;
    int   wt[NA];
    bit   rdy;
    int   fid;
    int   a;
    src_areg_i = s_src; w_en_i = s_wen; dst_areg_i = s_dst; new_preg_i = s_new;
    ckpt_take_i = s_take; ckpt_release_i = s_rel; ckpt_release_id_i = s_relid;
    restore_i = s_res; restore_id_i = s_resid; restore_kill_mask_i = s_kmask; rst = s_rst;
    rdy = 0; fid = 0;
    for (int i = NC - 1; i >= 0; i--) if (!m_busy[i]) begin rdy = 1; fid = i; end
    // Lanes renamed one after another: each sees the writes of the older lanes.
    wt = m_tab;
    e = '0;
    for (int k = 0; k < RW; k++) begin
      for (int s = 0; s < 2; s++) begin
        a = int'(s_src[2*AW*k + AW*s +: AW]);
        e.src[2*PW*k + PW*s +: PW] = PW'(wt[a]);
      end
      a = int'(s_dst[AW*k +: AW]);
      e.old[PW*k +: PW] = PW'(wt[a]);
      e.oldv[k] = s_wen[k];
      if (s_wen[k]) wt[a] = int'(s_new[PW*k +: PW]);
    end
    e.rdy = rdy;
    e.id  = CW'(fid);
    if (!s_rst) sb.push_back(e);
    if (s_rst) begin
      for (int i = 0; i < NA; i++) m_tab[i] = i;
      for (int i = 0; i < NC; i++) m_busy[i] = 0;
    end else if (s_res) begin
      m_tab = m_snap[s_resid];
      m_busy[s_resid] = 0;
      for (int i = 0; i < NC; i++) if (s_kmask[i]) m_busy[i] = 0;
    end else begin
      m_tab = wt;
      if (s_rel) m_busy[s_relid] = 0;
      if (s_take && rdy) begin
        m_snap[fid] = wt;
        m_busy[fid] = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (src_preg_o !== e.src) begin
        errors++;
        $display("FAIL src_preg t=%0t got=%h exp=%h", $time, src_preg_o, e.src);
      end
      for (int k = 0; k < RW; k++) begin
        if (e.oldv[k]) begin
          checks++;
          if (old_preg_o[PW*k +: PW] !== e.old[PW*k +: PW]) begin
            errors++;
            $display("FAIL old_preg lane%0d t=%0t got=%0d exp=%0d", k, $time,
                     old_preg_o[PW*k +: PW], e.old[PW*k +: PW]);
          end
        end
      end
      checks++;
      if (ckpt_ready_o !== e.rdy) begin
        errors++;
        $display("FAIL ckpt_ready t=%0t got=%b exp=%b", $time, ckpt_ready_o, e.rdy);
      end
      if (e.rdy) begin
        checks++;
        if (ckpt_id_o !== e.id) begin
          errors++;
          $display("FAIL ckpt_id t=%0t got=%0d exp=%0d", $time, ckpt_id_o, e.id);
        end
      end
    end
  end

  initial begin
    int nb;
    int bl[$];
    idle();
    src_areg_i = '0; w_en_i = '0; dst_areg_i = '0; new_preg_i = '0; ckpt_take_i = 0;
    ckpt_release_i = 0; ckpt_release_id_i = '0; restore_i = 0; restore_id_i = '0;
    restore_kill_mask_i = '0; rst = 1;
    @(posedge clk); #1;

    // Reset, then read every areg through all four source ports.
    idle(); s_rst = 1; step(); step();
    for (int i = 0; i < NA / 4; i++) begin
      idle();
      set_src(0, 0, 4*i); set_src(0, 1, 4*i+1); set_src(1, 0, 4*i+2); set_src(1, 1, 4*i+3);
      step();
    end

    // Same-group bypass of r5.
    idle(); set_wr(0, 5, 40); set_src(1, 0, 5); s_dst[AW +: AW] = 5; step();
    idle(); set_src(0, 0, 5); step();

    // Same-destination conflict on r3.
    idle(); set_wr(0, 3, 41); set_wr(1, 3, 42); set_src(1, 1, 3); step();
    idle(); set_src(0, 0, 3); step();

    // Take with write, overwrite, restore.
    idle(); set_wr(0, 7, 50); s_take = 1; step();
    idle(); set_wr(1, 7, 51); set_src(0, 0, 7); step();
    idle(); s_res = 1; s_resid = 0; set_wr(0, 7, 52); s_take = 1; step();
    idle(); set_src(0, 0, 7); set_src(1, 1, 7); step();

    // Exhaust all slots, stalled take, release with take.
    for (int i = 0; i < 4; i++) begin
      idle(); set_wr(i % 2, 10 + i, 20 + i); s_take = 1; step();
    end
    idle(); s_take = 1; step();
    idle(); s_take = 1; s_rel = 1; s_relid = 2; step();
    idle(); step();

    // Restore slot 1 with younger slots killed and a dropped same-cycle write.
    idle(); s_rst = 1; step();
    idle(); set_wr(0, 9, 33); s_take = 1; step();
    idle(); set_wr(0, 9, 34); set_wr(1, 11, 35); s_take = 1; step();
    idle(); set_wr(0, 9, 36); s_take = 1; step();
    idle(); set_wr(1, 12, 37); s_take = 1; step();
    idle(); s_res = 1; s_resid = 1; s_kmask = 4'b1100; set_wr(0, 9, 60); step();
    idle(); set_src(0, 0, 9); set_src(0, 1, 11); set_src(1, 0, 12); s_take = 1; step();
    for (int i = 0; i < NA / 4; i++) begin
      idle();
      set_src(0, 0, 4*i); set_src(0, 1, 4*i+1); set_src(1, 0, 4*i+2); set_src(1, 1, 4*i+3);
      step();
    end

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 1500; n++) begin
      idle();
      s_src = RW*2*AW'($urandom);
      for (int k = 0; k < RW; k++) begin
        for (int s = 0; s < 2; s++) set_src(k, s, $urandom_range(NA - 1));
        if ($urandom_range(3) != 0) set_wr(k, $urandom_range(NA - 1), $urandom_range(NP - 1));
        else s_dst[AW*k +: AW] = AW'($urandom_range(NA - 1));
      end
      if ($urandom_range(2) == 0) s_take = 1;
      if ($urandom_range(3) == 0) begin s_rel = 1; s_relid = CW'($urandom_range(NC - 1)); end
      bl.delete();
      for (int i = 0; i < NC; i++) if (m_busy[i]) bl.push_back(i);
      nb = bl.size();
      if (nb > 0 && $urandom_range(7) == 0) begin
        s_res = 1;
        s_resid = CW'(bl[$urandom_range(nb - 1)]);
        s_kmask = NC'($urandom);
      end
      if ($urandom_range(199) == 0) s_rst = 1;
      step();
    end

    idle(); step();
    @(negedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
